axis_queue_admit: RTL

Multi-queue AXI4-Stream ingress admission block for the SRAM/RLDRAM packet buffer path. Each packet's destination queue is taken from `s_tdest`. At the first beat the block reserves that packet's whole memory footprint against a per-queue credit counter, and either admits the packet or silently drops it. Admitted beats are packed with length, queue ID and byte count into a single-clock FWFT FIFO that feeds the memory write scheduler. Freed memory is returned by the scheduler as credits.

---
 rtl/axis_queue_admit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/axis_queue_admit.sv
// Multi-queue AXI4-Stream ingress admission: per-queue credit reservation, drop, FWFT output FIFO.
// Optional statistics counters are enabled by defining AXIS_QUEUE_ADMIT_STATS_EN.
module axis_queue_admit #(
  parameter int unsigned TDATA_WIDTH         = 32,
  parameter int unsigned TUSER_WIDTH         = 128,
  parameter int unsigned TDEST_WIDTH         = 4,
  parameter int unsigned NUM_QUEUES          = 4,
  parameter int unsigned QUEUE_ID_WIDTH      = 2,
  parameter int unsigned QUEUE_WORDS         = 65536,
  parameter int unsigned CREDIT_WIDTH        = 18,
  parameter int unsigned MEM_WORD_BYTES_LOG2 = 3,
  parameter int unsigned FIFO_ADDR_WIDTH     = 5,
  localparam int unsigned BCW = $clog2(TDATA_WIDTH) + 1,
  localparam int unsigned MW  = 16 + QUEUE_ID_WIDTH + 8*TDATA_WIDTH + BCW + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cal_done,
  input  logic                        s_tvalid,
  output logic                        s_tready,
  input  logic [8*TDATA_WIDTH-1:0]    s_tdata,
  input  logic [TDATA_WIDTH-1:0]      s_tstrb,
  input  logic                        s_tlast,
  input  logic [TDEST_WIDTH-1:0]      s_tdest,
  input  logic [TUSER_WIDTH-1:0]      s_tuser,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [MW-1:0]               m_data,
  output logic [FIFO_ADDR_WIDTH:0]    fifo_level,
  input  logic                        credit_ret_valid,
  input  logic [QUEUE_ID_WIDTH-1:0]   credit_ret_queue,
  input  logic [15:0]                 credit_ret_words,
  output logic                        drop_pulse,
  output logic [31:0]                 stat_beats,
  output logic [31:0]                 stat_admit,
  output logic [31:0]                 stat_drop
);

  localparam int unsigned DEPTH = 2**FIFO_ADDR_WIDTH;
  localparam int unsigned LW    = FIFO_ADDR_WIDTH + 1;
  localparam int unsigned SW    = CREDIT_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t                      state_q;
  logic [QUEUE_ID_WIDTH-1:0]   qid_q;
  logic [15:0]                 len_q;
  logic [CREDIT_WIDTH-1:0]     credit_q [NUM_QUEUES];
  logic [CREDIT_WIDTH-1:0]     credit_d [NUM_QUEUES];
  logic [MW-1:0]               mem_q [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]               level_q;
  logic                        drop_pulse_q;

  logic                        fifo_full, hs, first, dest_ok, admit, reserve, drop, push, pop;
  logic [QUEUE_ID_WIDTH-1:0]   q_in;
  logic [16:0]                 need;
  logic [CREDIT_WIDTH-1:0]     cur_credit;
  logic [BCW-1:0]              byte_cnt;
  logic [MW-1:0]               push_word;
  logic                        unused_tuser;

  assign unused_tuser = ^s_tuser[TUSER_WIDTH-1:16];

  assign fifo_full = (level_q == LW'(DEPTH));
  assign s_tready  = cal_done && !reset && ((state_q == DROP) || !fifo_full);
  assign hs        = s_tvalid && s_tready;
  assign first     = hs && (state_q == IDLE);
  assign q_in      = s_tdest[QUEUE_ID_WIDTH-1:0];
  assign dest_ok   = 32'(s_tdest) < NUM_QUEUES;
  assign need      = (17'(s_tuser[15:0]) + 17'((2**MEM_WORD_BYTES_LOG2) - 1)) >> MEM_WORD_BYTES_LOG2;
  assign cur_credit = dest_ok ? credit_q[q_in] : '0;
  // Strict compare keeps one word of margin in every queue
  assign admit     = dest_ok && (SW'(cur_credit) > SW'(need));
  assign reserve   = first && admit;
  assign drop      = first && !admit;
  assign push      = reserve || (hs && (state_q == PASS));
  assign pop       = m_valid && m_ready;

  always_comb begin
    byte_cnt = '0;
    for (int i = 0; i < TDATA_WIDTH; i++) byte_cnt = byte_cnt + BCW'(s_tstrb[i]);
  end

  assign push_word = {(state_q == IDLE) ? s_tuser[15:0] : len_q,
                      (state_q == IDLE) ? q_in : qid_q,
                      s_tdata, byte_cnt, s_tlast};

  // Net credit: reservation and return may land on the same queue in one cycle
  always_comb begin
    logic [SW-1:0] sum;
    sum = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      sum = SW'(credit_q[i]);
      if (reserve && (q_in == QUEUE_ID_WIDTH'(i))) sum = sum - SW'(need);
      if (credit_ret_valid && (credit_ret_queue == QUEUE_ID_WIDTH'(i)))
        sum = sum + SW'(credit_ret_words);
      credit_d[i] = (sum > SW'(QUEUE_WORDS)) ? CREDIT_WIDTH'(QUEUE_WORDS) : CREDIT_WIDTH'(sum);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      qid_q        <= '0;
      len_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      drop_pulse_q <= 1'b0;
      for (int i = 0; i < NUM_QUEUES; i++) credit_q[i] <= CREDIT_WIDTH'(QUEUE_WORDS);
    end else begin
      drop_pulse_q <= drop;
      for (int i = 0; i < NUM_QUEUES; i++) credit_q[i] <= credit_d[i];
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + LW'(push) - LW'(pop);
      case (state_q)
        IDLE: if (first) begin
          if (admit) begin
            qid_q <= q_in;
            len_q <= s_tuser[15:0];
          end
          if (!s_tlast) state_q <= admit ? PASS : DROP;
        end
        PASS, DROP: if (hs && s_tlast) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

  assign m_valid    = (level_q != '0);
  assign m_data     = m_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level = level_q;
  assign drop_pulse = drop_pulse_q;

`ifdef AXIS_QUEUE_ADMIT_STATS_EN
  logic [31:0] stat_beats_q, stat_admit_q, stat_drop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_beats_q <= '0;
      stat_admit_q <= '0;
      stat_drop_q  <= '0;
    end else begin
      stat_beats_q <= stat_beats_q + 32'(hs);
      stat_admit_q <= stat_admit_q + 32'(reserve);
      stat_drop_q  <= stat_drop_q + 32'(drop);
    end
  end

  assign stat_beats = stat_beats_q;
  assign stat_admit = stat_admit_q;
  assign stat_drop  = stat_drop_q;
`else
  assign stat_beats = '0;
  assign stat_admit = '0;
  assign stat_drop  = '0;
`endif

endmodule
